popcount_sequencer: RTL
=======================

// Module: popcount_sequencer
// PURPOSE
//   Multi-cycle Hamming-weight engine for words wider than the shared popcount slice.
//   Accepts one WIDTH-bit word on a valid/ready input, feeds it SLICE bits per cycle
//   through one population_counter instance (bits=SLICE), and accumulates the slice counts.
//   Returns the total on a valid/ready output.
//   Sits between a word producer (e.g. FIFO) and any weight consumer; trades latency for area.
// PARAMETERS
//   WIDTH  16  input word width; must be a multiple of SLICE (elaboration error otherwise)
//   SLICE  4   bits counted per cycle (bits parameter of the population_counter instance)
//   derived: N = WIDTH/SLICE slices; CW = $clog2(WIDTH)+1 count width
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      in_data valid
//   in_ready   out  1      block can accept a word (high only in IDLE)
//   in_data    in   WIDTH  word to count
//   out_valid  out  1      out_count valid (high only in DONE)
//   out_ready  in   1      consumer accepts out_count
//   out_count  out  CW     number of 1s in the accepted word (0..WIDTH)
//   busy       out  1      high in RUN or DONE
// BEHAVIOUR
//   - Reset: state=IDLE; out_valid=0, out_count=0, busy=0, in_ready=1; shift reg and slice idx cleared.
//   - Outputs are registered or decoded from state only; there is no comb path in_* -> out_*.
//   - FSM:
//       IDLE: on in_valid&in_ready -> load shreg=in_data, acc=0, idx=0, go RUN. Else stay.
//       RUN: each cycle acc += popcount(shreg[SLICE-1:0]), shreg >>= SLICE, idx++.
//            On the edge that processes slice N-1 -> out_count=final acc, go DONE.
//       DONE: hold out_count and out_valid=1. On out_valid&out_ready -> go IDLE.
//   - Latency: word accepted at edge k -> out_valid high after edge k+N (N=4 at defaults).
//   - Throughput: at most one word per N+2 cycles. in_ready is low in RUN/DONE and
//     in_valid is ignored there. A new word can be accepted on the first IDLE cycle after
//     the output handshake.
//   - Width: acc is CW bits and cannot overflow (max WIDTH < 2^CW). Slice count is zero-extended.
//   - out_count holds its last value in IDLE until the next DONE; consumers qualify with out_valid.
//   - rst in any state (incl. mid-RUN) -> IDLE next edge. The partial count is discarded
//     and no out_valid is issued.
//   - SLICE==WIDTH is legal: N=1, single RUN cycle.
// CONFIGURATION
//   POPCNT_THRESH_EN defined:
//     - adds input thresh[CW-1:0] and output out_ge (1 bit).
//     - out_ge is registered with out_count on the RUN->DONE edge: out_ge = (final count >= thresh).
//     - thresh is sampled on the in_valid&in_ready edge and held internally.
//     - out_ge resets to 0.
//   POPCNT_THRESH_EN undefined: thresh and out_ge ports absent. No compare logic.
// TESTING (WIDTH=16, SLICE=4 unless noted)
//   1. rst=1 for 2 cycles -> in_ready=1, out_valid=0, out_count=0, busy=0.
//   2. in_data=16'hFFFF accepted -> out_valid rises exactly 4 cycles later, out_count=16.
//      Then 16'h0000 -> 0, and 16'hA5A5 -> 8.
//   3. Backpressure: out_ready=0 for 6 cycles after DONE with in_valid=1, in_data=16'h0001.
//      -> out_count holds, in_ready=0, the held word is not consumed. Then out_ready=1
//      -> next cycle IDLE, the word is accepted, and its result is 1.
//   4. Reset mid-RUN: accept 16'hFFFF, assert rst 2 cycles later -> IDLE next edge,
//      no out_valid pulse. A following 16'h0F0F yields 8.
//   5. Back-to-back: 3 words 16'h8001, 16'h7FFE, 16'hFFFF with in_valid held and out_ready=1
//      -> counts 2, 14, 16 in order, N+2 cycles apart. Repeat with SLICE=16 (N=1).
//   6. POPCNT_THRESH_EN: 16'h00FF with thresh=9 -> out_ge=0; same word with thresh=8 -> out_ge=1.

Source files
------------

// File: rtl/popcount_sequencer.sv
// Hamming weight of a WIDTH-bit word, SLICE bits per cycle through one shared slice counter; POPCNT_THRESH_EN adds a threshold compare.
// Latency: result valid N=WIDTH/SLICE cycles after the input handshake; one word per N+2 cycles at best.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.

module population_counter #(
    parameter  int bits = 4,
    localparam int CW   = $clog2(bits) + 1
) (
    input  logic [bits-1:0] data,
    output logic [CW-1:0]   count
);
    always_comb begin
        count = '0;
        for (int i = 0; i < bits; i++) begin
            count = count + CW'(data[i]);
        end
    end
endmodule

module popcount_sequencer #(
    parameter  int WIDTH = 16,
    parameter  int SLICE = 4,
    localparam int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
`ifdef POPCNT_THRESH_EN
    input  logic [CW-1:0]    thresh,
    output logic             out_ge,
`endif
    output logic             busy
);
    localparam int N  = WIDTH / SLICE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = $clog2(SLICE) + 1;

    if ((WIDTH % SLICE) != 0) begin : g_bad_width
        $error("popcount_sequencer: WIDTH must be a multiple of SLICE");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    acc;
    logic [CW-1:0]    acc_nxt;
    logic [IW-1:0]    idx;
    logic [SW-1:0]    slice_cnt;
    logic             last_slice;

    population_counter #(.bits(SLICE)) u_slice_cnt (
        .data  (shreg[SLICE-1:0]),
        .count (slice_cnt)
    );

    assign acc_nxt    = acc + CW'(slice_cnt);
    assign last_slice = (idx == IW'(N - 1));
    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)   state_nxt = RUN;
            RUN:     if (last_slice) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // out_count is only written on the final RUN edge, so it holds through IDLE and RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg     <= '0;
            acc       <= '0;
            idx       <= '0;
            out_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg <= in_data;
                        acc   <= '0;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    shreg <= shreg >> SLICE;
                    acc   <= acc_nxt;
                    idx   <= idx + IW'(1);
                    if (last_slice) begin
                        out_count <= acc_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef POPCNT_THRESH_EN
    logic [CW-1:0] thresh_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            thresh_q <= '0;
            out_ge   <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            thresh_q <= thresh;
        end else if (state == RUN && last_slice) begin
            out_ge <= (acc_nxt >= thresh_q);
        end
    end
`endif

endmodule
